// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch / load-store requesters, the arbiter and the RAM.
// slave modport: the arbiter's view. master modport: requester/RAM side view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_dout,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_addr, mem_we, mem_din
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_dout,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: fetch vs load/store, fixed priority ls > if.
// Owner FSM tags the read in flight so returning data reaches its requester.
// Optional macro MEM_ARB_STARVE_GUARD_EN adds a wait counter that forces a
// fetch grant after MAX_WAIT consecutive denied fetch cycles.
module mem_port_arbiter #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_port_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    LS_RD = 2'd2
  } state_t;

  state_t state_r;
  state_t next_state_s;
  logic   if_gnt_s;
  logic   ls_gnt_s;
  logic   force_if_s;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] wait_cnt_r;

  // Count consecutive cycles a fetch request is denied; saturate at 15.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= 4'd0;
    end else if (if_gnt_s) begin
      wait_cnt_r <= 4'd0;
    end else if (bus.if_req && (wait_cnt_r != 4'hF)) begin
      wait_cnt_r <= wait_cnt_r + 4'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign force_if_s = (wait_cnt_r == 4'(MAX_WAIT));
`else
  assign force_if_s = 1'b0;
`endif

  // Grant decision: ls wins contention unless the guard is forcing fetch.
  always_comb begin
    if_gnt_s = 1'b0;
    ls_gnt_s = 1'b0;
    if (!rst_n) begin
      if_gnt_s = 1'b0;
      ls_gnt_s = 1'b0;
    end else if (bus.if_req && (force_if_s || !bus.ls_req)) begin
      if_gnt_s = 1'b1;
    end else if (bus.ls_req) begin
      ls_gnt_s = 1'b1;
    end else begin
      if_gnt_s = 1'b0;
      ls_gnt_s = 1'b0;
    end
  end

  // Owner state register; reset drops any in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next owner follows this cycle's grant; stores and idle cycles leave nothing in flight.
  always_comb begin
    next_state_s = IDLE;
    if (if_gnt_s) begin
      next_state_s = IF_RD;
    end else if (ls_gnt_s && !bus.ls_we) begin
      next_state_s = LS_RD;
    end else begin
      next_state_s = IDLE;
    end
  end

  // Drive grants, RAM controls and read returns; everything low while in reset.
  always_comb begin
    bus.if_gnt    = 1'b0;
    bus.ls_gnt    = 1'b0;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_we    = 1'b0;
    bus.mem_din   = {DATA_W{1'b0}};
    bus.if_rvalid = 1'b0;
    bus.ls_rvalid = 1'b0;
    bus.if_rdata  = {DATA_W{1'b0}};
    bus.ls_rdata  = {DATA_W{1'b0}};
    if (rst_n) begin
      bus.if_gnt    = if_gnt_s;
      bus.ls_gnt    = ls_gnt_s;
      bus.mem_we    = ls_gnt_s & bus.ls_we;
      bus.mem_din   = bus.ls_wdata;
      bus.if_rvalid = (state_r == IF_RD);
      bus.ls_rvalid = (state_r == LS_RD);
      bus.if_rdata  = bus.mem_dout;
      bus.ls_rdata  = bus.mem_dout;
      if (if_gnt_s) begin
        bus.mem_addr = bus.if_addr;
      end else if (ls_gnt_s) begin
        bus.mem_addr = bus.ls_addr;
      end else begin
        bus.mem_addr = {ADDR_W{1'b0}};
      end
    end else begin
      bus.mem_addr = {ADDR_W{1'b0}};
    end
  end

endmodule
